data_cache_ctrl: RTL and testbench

Parametrised blocking data cache for the RV32I data path. It sits between the execute/memory stage and a word-wide backing memory. It replaces the single-cycle cache/memory pair with a direct-mapped, multi-word-line cache. Read misses are refilled over a request/acknowledge memory port, and writes go write-through with no allocate on miss. Misses and writes stall the pipeline. The block also provides single-cycle flush and hit/miss performance counters.

---
 rtl/data_cache_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_data_cache_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: blocking, direct-mapped, write-through / no-write-allocate data cache
// between the RV32I memory stage and a word-wide request/acknowledge backing memory.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid, wen, address,        CPU request (held stable while stall = 1)
//   write_data, byte_addr, flush
//   read_data, stall                load result (byte loads zero-extended), pipeline stall
//   mem_req, mem_we, mem_addr,      registered backing-memory request, stable until mem_ack
//   mem_wdata, mem_be
//   mem_ack, mem_rdata              memory completion and read data
//   hit_count, miss_count           saturating read hit / read miss counters
//
// DATA_WIDTH must be at least 16 so the lane-select field is non-empty.
module data_cache_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned SETS           = 64,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  input  logic                      wen,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH-1:0]     write_data,
  input  logic                      byte_addr,
  input  logic                      flush,
  output logic [DATA_WIDTH-1:0]     read_data,
  output logic                      stall,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
);

  localparam int unsigned LANES = DATA_WIDTH / 8;
  localparam int unsigned LB    = $clog2(LANES);
  localparam int unsigned WB    = $clog2(WORDS_PER_LINE);
  localparam int unsigned OFF   = WB + LB;
  localparam int unsigned IDX   = $clog2(SETS);
  localparam int unsigned TAG   = ADDR_WIDTH - IDX - OFF;

  typedef enum logic [1:0] {StIdle, StRefill, StWrite} state_e;

  // Address fields
  logic [LB-1:0]  a_lane;
  logic [WB-1:0]  a_word;
  logic [IDX-1:0] a_idx;
  logic [TAG-1:0] a_tag;

  assign a_lane = address[LB-1:0];
  assign a_word = address[OFF-1:LB];
  assign a_idx  = address[OFF+IDX-1:OFF];
  assign a_tag  = address[ADDR_WIDTH-1:OFF+IDX];

  // Storage: only the valid vector is reset, so the arrays carry no reset.
  logic [DATA_WIDTH-1:0] data_q [SETS*WORDS_PER_LINE];
  logic [TAG-1:0]        tag_q  [SETS];
  logic [SETS-1:0]       valid_q, valid_d;

  state_e              state_q, state_d;
  logic [WB-1:0]       cnt_q, cnt_d;
  logic                refilled_q, refilled_d;
  logic                flush_pend_q, flush_pend_d;
  logic [31:0]         hit_count_q, hit_count_d;
  logic [31:0]         miss_count_q, miss_count_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [LANES-1:0]    mem_be_q, mem_be_d;

  logic                  hit;
  logic                  ack;
  logic                  refill_ack;
  logic                  write_ack;
  logic                  last_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_shift;

  assign hit        = valid_q[a_idx] & (tag_q[a_idx] == a_tag);
  assign ack        = mem_ack & mem_req_q;
  assign refill_ack = (state_q == StRefill) & ack;
  assign write_ack  = (state_q == StWrite) & ack;
  assign last_word  = &cnt_q;
  assign rd_word    = data_q[{a_idx, a_word}];

  always_comb begin
    rd_shift  = rd_word >> {a_lane, 3'b000};
    read_data = byte_addr ? {{(DATA_WIDTH-8){1'b0}}, rd_shift[7:0]} : rd_word;
  end

  assign stall = req_valid & ~((state_q == StIdle) & ~wen & hit) & ~write_ack;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    refilled_d   = refilled_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (wen) begin
            state_d     = StWrite;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {address[ADDR_WIDTH-1:LB], {LB{1'b0}}};
            mem_be_d    = byte_addr ? (LANES'(1) << a_lane) : {LANES{1'b1}};
            mem_wdata_d = byte_addr ? {LANES{write_data[7:0]}} : write_data;
          end else if (hit) begin
            // The completion cycle after a refill is not a hit.
            if (refilled_q) begin
              refilled_d = 1'b0;
            end else if (hit_count_q != '1) begin
              hit_count_d = hit_count_q + 32'd1;
            end
          end else begin
            state_d    = StRefill;
            cnt_d      = '0;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_be_d   = {LANES{1'b1}};
            mem_addr_d = {a_tag, a_idx, {OFF{1'b0}}};
            if (miss_count_q != '1) begin
              miss_count_d = miss_count_q + 32'd1;
            end
          end
        end
        if (flush) begin
          valid_d = '0;
        end
      end
      StRefill: begin
        if (flush) begin
          flush_pend_d = 1'b1;
        end
        if (ack) begin
          cnt_d = cnt_q + WB'(1);
          if (last_word) begin
            state_d        = StIdle;
            valid_d[a_idx] = 1'b1;
            refilled_d     = 1'b1;
            mem_req_d      = 1'b0;
          end else begin
            mem_addr_d = {a_tag, a_idx, cnt_q + WB'(1), {LB{1'b0}}};
          end
        end
      end
      StWrite: begin
        if (flush) begin
          flush_pend_d = 1'b1;
        end
        if (ack) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // A deferred flush lands on the edge back into IDLE and beats a refill's valid set.
    if ((state_q != StIdle) && (state_d == StIdle) && (flush_pend_q || flush)) begin
      valid_d      = '0;
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      refilled_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      refilled_q   <= refilled_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
    end
  end

  // Data and tag arrays; a reset edge suppresses writes so an aborted refill stays discarded.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (refill_ack) begin
        data_q[{a_idx, cnt_q}] <= mem_rdata;
        if (last_word) begin
          tag_q[a_idx] <= a_tag;
        end
      end
      if (write_ack && hit) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          if (mem_be_q[l]) begin
            data_q[{a_idx, a_word}][8*l +: 8] <= mem_wdata_q[8*l +: 8];
          end
        end
      end
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: directed scenarios followed by randomized
// loads/stores/flushes, checked against a line-level cache model and a reference memory.
module tb_data_cache_ctrl;

  localparam int unsigned WPL   = 4;
  localparam int unsigned NSETS = 64;
  localparam int          LIMIT = 300;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        wen;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        byte_addr;
  logic        flush;
  logic [31:0] read_data;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  data_cache_ctrl #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .SETS          (NSETS),
    .WORDS_PER_LINE(WPL)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .wen       (wen),
    .address   (address),
    .write_data(write_data),
    .byte_addr (byte_addr),
    .flush     (flush),
    .read_data (read_data),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory seen by the responder (written from DUT outputs) and the reference memory
  // (written from the stimulus); untouched words come from a fixed hash.
  logic [31:0] mem     [int unsigned];
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] init_word(input int unsigned a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] mem_word(input int unsigned a);
    if (mem.exists(a)) return mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // Cache model: which line (tag) each set holds
  bit          valid_m [NSETS];
  int unsigned tag_m   [NSETS];
  int unsigned exp_hit  = 0;
  int unsigned exp_miss = 0;
  logic [31:0] last_rd;

  // Responder log
  logic        q_we    [$];
  logic [31:0] q_addr  [$];
  logic [3:0]  q_be    [$];
  logic [31:0] q_wdata [$];
  int unsigned q_wait  [$];
  int unsigned ack_max = 0;

  initial begin
    int unsigned wl;
    int unsigned w0;
    bit          busy;
    logic [31:0] m;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    busy      = 1'b0;
    wl        = 0;
    w0        = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst_n && mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          wl   = $urandom_range(ack_max, 0);
          w0   = wl;
        end
        if (wl == 0) begin
          mem_ack = 1'b1;
          busy    = 1'b0;
          q_we.push_back(mem_we);
          q_addr.push_back(mem_addr);
          q_be.push_back(mem_be);
          q_wdata.push_back(mem_wdata);
          q_wait.push_back(w0);
          if (mem_we) begin
            m = mem_word(mem_addr & ~32'h3);
            for (int l = 0; l < 4; l++) begin
              if (mem_be[l]) m[8*l +: 8] = mem_wdata[8*l +: 8];
            end
            mem[mem_addr & ~32'h3] = m;
          end else begin
            mem_rdata = mem_word(mem_addr & ~32'h3);
          end
        end else begin
          wl--;
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  task automatic clear_log();
    q_we.delete();
    q_addr.delete();
    q_be.delete();
    q_wdata.delete();
    q_wait.delete();
  endtask

  task automatic model_flush();
    foreach (valid_m[i]) valid_m[i] = 1'b0;
  endtask

  // One CPU access; flush_at >= 0 pulses flush in that stalled cycle (load misses only).
  task automatic do_access(input logic we, input logic [31:0] addr, input logic byt,
                           input logic [31:0] wd, input int flush_at);
    int unsigned idx;
    int unsigned tg;
    int unsigned misses;
    int unsigned exp_txn;
    int unsigned wsum;
    int          cyc;
    int          b;
    bit          hit_m;
    logic [31:0] exp_rd;
    logic [31:0] w;
    logic [31:0] base;

    idx    = (addr >> 4) % NSETS;
    tg     = addr >> 10;
    b      = int'(addr[1:0]);
    hit_m  = valid_m[idx] && (tag_m[idx] == tg);
    misses = 0;
    if (!we && !hit_m) misses = (flush_at >= 0) ? 2 : 1;
    exp_txn = we ? 1 : misses * WPL;
    w       = ref_word(addr & ~32'h3);
    exp_rd  = byt ? ((w >> (8 * b)) & 32'hFF) : w;
    base    = addr & ~32'hF;
    clear_log();

    @(negedge clk);
    req_valid  = 1'b1;
    wen        = we;
    address    = addr;
    byte_addr  = byt;
    write_data = wd;
    #1;
    cyc = 0;
    while (stall && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      flush = (cyc == flush_at);
      #1;
    end
    flush = 1'b0;

    check("stall_clear", {31'b0, stall}, 32'd0);
    if (!we) check($sformatf("rdata@%08h", addr), read_data, exp_rd);
    last_rd = read_data;
    check("txn_count", 32'(q_we.size()), exp_txn);
    wsum = 0;
    for (int k = 0; k < q_we.size() && k < int'(exp_txn); k++) begin
      wsum += q_wait[k];
      if (we) begin
        check("wr_we", {31'b0, q_we[k]}, 32'd1);
        check("wr_addr", q_addr[k], addr & ~32'h3);
        check("wr_be", {28'b0, q_be[k]}, byt ? (32'd1 << b) : 32'hF);
        check("wr_wdata", q_wdata[k], byt ? {4{wd[7:0]}} : wd);
      end else begin
        check("rf_we", {31'b0, q_we[k]}, 32'd0);
        check("rf_addr", q_addr[k], base + 32'(4 * (k % WPL)));
        check("rf_be", {28'b0, q_be[k]}, 32'hF);
      end
    end
    check("stall_cycles", 32'(cyc), we ? (1 + wsum) : (misses * (1 + WPL) + wsum));

    @(posedge clk);
    #1;
    req_valid = 1'b0;

    if (we) begin
      w = ref_word(addr & ~32'h3);
      if (byt) w[8*b +: 8] = wd[7:0];
      else     w = wd;
      ref_mem[addr & ~32'h3] = w;
    end else if (misses > 0) begin
      if (flush_at >= 0) model_flush();
      valid_m[idx] = 1'b1;
      tag_m[idx]   = tg;
      exp_miss    += misses;
    end else begin
      exp_hit++;
    end
    check("hit_count", hit_count, exp_hit);
    check("miss_count", miss_count, exp_miss);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cyc;
    int unsigned sel;
    logic [31:0] a;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    wen        = 1'b0;
    address    = '0;
    write_data = '0;
    byte_addr  = 1'b0;
    flush      = 1'b0;
    model_flush();
    foreach (tag_m[i]) tag_m[i] = 0;
    mem[32'h100]     = 32'h11;  ref_mem[32'h100] = 32'h11;
    mem[32'h104]     = 32'h22;  ref_mem[32'h104] = 32'h22;
    mem[32'h108]     = 32'h33;  ref_mem[32'h108] = 32'h33;
    mem[32'h10C]     = 32'hAABB_CC44;
    ref_mem[32'h10C] = 32'hAABB_CC44;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be", {28'b0, mem_be}, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    req_valid = 1'b1;
    address   = 32'h100;
    #1;
    check("rst_load_stalls", {31'b0, stall}, 32'd1);
    req_valid = 1'b0;
    #1;
    check("rst_idle_no_stall", {31'b0, stall}, 32'd0);

    // Directed scenarios with back-to-back acks
    ack_max = 0;
    do_access(1'b0, 32'h100, 1'b0, 32'h0, -1);
    check("lw_0x100", last_rd, 32'h11);
    do_access(1'b0, 32'h108, 1'b0, 32'h0, -1);
    check("lw_0x108", last_rd, 32'h33);
    do_access(1'b0, 32'h10D, 1'b1, 32'h0, -1);
    check("lbu_0x10d", last_rd, 32'hCC);
    ack_max = 2;
    do_access(1'b1, 32'h102, 1'b1, 32'hDEAD_BE5A, -1);
    do_access(1'b0, 32'h100, 1'b0, 32'h0, -1);
    check("lw_merged", last_rd, 32'h005A_0011);
    do_access(1'b1, 32'h2000, 1'b0, 32'h1234_5678, -1);
    do_access(1'b0, 32'h2000, 1'b0, 32'h0, -1);
    do_access(1'b0, 32'h100 + NSETS * WPL * 4, 1'b0, 32'h0, -1);
    do_access(1'b0, 32'h100, 1'b0, 32'h0, -1);
    do_access(1'b0, 32'h300, 1'b0, 32'h0, 2);
    do_access(1'b0, 32'h100, 1'b0, 32'h0, -1);

    // Reset while the second refill word is outstanding
    clear_log();
    @(negedge clk);
    req_valid = 1'b1;
    wen       = 1'b0;
    byte_addr = 1'b0;
    address   = 32'h740;
    #1;
    cyc = 0;
    while (q_we.size() < 1 && cyc < LIMIT) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("first_word_acked", {31'b0, (q_we.size() >= 1)}, 32'd1);
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mid_hits", hit_count, 32'd0);
    check("rst_mid_misses", miss_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_flush();
    exp_hit  = 0;
    exp_miss = 0;
    do_access(1'b0, 32'h740, 1'b0, 32'h0, -1);

    // Randomized traffic over a small set of conflicting lines
    for (int n = 0; n < 400; n++) begin
      ack_max = $urandom_range(3, 0);
      sel     = $urandom_range(99, 0);
      a = 32'($urandom_range(3, 0) * 1024 + $urandom_range(3, 0) * 16
              + $urandom_range(3, 0) * 4);
      if (sel < 6) begin
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_flush();
      end else if (sel < 10) begin
        @(negedge clk);
        req_valid = 1'b0;
        wen       = 1'($urandom_range(1, 0));
        address   = $urandom;
        repeat ($urandom_range(3, 1)) @(negedge clk);
      end else if (sel < 40) begin
        do_access(1'b0, a, 1'b0, 32'h0, -1);
      end else if (sel < 60) begin
        do_access(1'b0, a | 32'($urandom_range(3, 0)), 1'b1, 32'h0, -1);
      end else if (sel < 66) begin
        do_access(1'b0, a, 1'b0, 32'h0, 2);
      end else if (sel < 83) begin
        do_access(1'b1, a, 1'b0, $urandom, -1);
      end else begin
        do_access(1'b1, a | 32'($urandom_range(3, 0)), 1'b1, $urandom, -1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
